// File: rtl/alu16_sequencer.sv
// Multi-byte ADD/ADC/SBC sequencer driving a shared 8-bit ALU one byte per cycle.
// It latches a request, runs N_BYTES byte passes and then holds the result and F flags until the handshake.
module alu16_sequencer #(
  parameter int unsigned N_BYTES = 2,
  localparam int unsigned W = 8 * N_BYTES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [7:0]   req_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [7:0]   rsp_flags,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_cin,
  output logic         alu_sub,
  input  logic [7:0]   alu_result,
  input  logic         alu_cout,
  input  logic         alu_hout,
  output logic         busy
);

  localparam int unsigned K_W = $clog2(N_BYTES);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_ADC = 2'b01, OP_SBC = 2'b10, OP_RSV = 2'b11} op_t;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [K_W-1:0] k_q, k_d, kn;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]     flags_q, flags_d;
  logic           nz_q, nz_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic [7:0]     rsp_flags_q, rsp_flags_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic           alu_cin_q, alu_cin_d, alu_sub_q, alu_sub_d;

  logic [W-1:0]   pass_res;
  logic           nz_next, sa, sb, sr;
  logic [7:0]     fin_flags;
  op_t            req_op_e;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    k_d          = k_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    flags_d      = flags_q;
    nz_d         = nz_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_valid_d  = rsp_valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    alu_sub_d    = alu_sub_q;
    req_op_e     = op_t'(req_op);

    kn       = k_q + 1'b1;
    pass_res = res_q;
    pass_res[8*k_q +: 8] = alu_result;
    nz_next  = nz_q | (|alu_result);
    sa       = a_q[W-1];
    sb       = b_q[W-1];
    sr       = pass_res[W-1];

    // ADD only touches H/N/C; ADC/SBC rebuild every flag except bits 5 and 3.
    fin_flags = flags_q;
    case (op_q)
      OP_ADD: begin
        fin_flags[4] = alu_hout;
        fin_flags[1] = 1'b0;
        fin_flags[0] = alu_cout;
      end
      OP_ADC, OP_SBC: begin
        fin_flags[7] = sr;
        fin_flags[6] = ~nz_next;
        fin_flags[4] = alu_hout;
        fin_flags[2] = (op_q == OP_SBC) ? ((sa ^ sb) & (sa ^ sr)) : (~(sa ^ sb) & (sa ^ sr));
        fin_flags[1] = (op_q == OP_SBC);
        fin_flags[0] = alu_cout;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d   = S_PASS;
          op_d      = req_op_e;
          a_d       = req_a;
          b_d       = req_b;
          flags_d   = req_flags;
          k_d       = '0;
          res_d     = '0;
          nz_d      = 1'b0;
          // Byte-0 operands are registered at accept so the ALU sees them in the first pass cycle.
          alu_a_d   = req_a[7:0];
          alu_b_d   = req_b[7:0];
          alu_sub_d = (req_op_e == OP_SBC);
          alu_cin_d = ((req_op_e == OP_ADC) || (req_op_e == OP_SBC)) ? req_flags[0] : 1'b0;
        end
      end
      S_PASS: begin
        res_d = pass_res;
        nz_d  = nz_next;
        if (k_q == K_LAST) begin
          state_d      = S_DONE;
          rsp_valid_d  = 1'b1;
          rsp_result_d = (op_q == OP_RSV) ? a_q : pass_res;
          rsp_flags_d  = fin_flags;
          alu_a_d      = '0;
          alu_b_d      = '0;
          alu_cin_d    = 1'b0;
          alu_sub_d    = 1'b0;
        end else begin
          k_d       = kn;
          alu_a_d   = a_q[8*kn +: 8];
          alu_b_d   = b_q[8*kn +: 8];
          alu_cin_d = alu_cout;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      k_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      nz_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      alu_sub_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      k_q          <= k_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      nz_q         <= nz_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_valid_q  <= rsp_valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      alu_sub_q    <= alu_sub_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign alu_sub    = alu_sub_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Scoreboard bench for alu16_sequencer with a behavioural Z80-style 8-bit ALU attached.
module tb_alu16_sequencer;
  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_b, rsp_result;
  logic [7:0]   req_flags, rsp_flags;
  logic [7:0]   alu_a, alu_b, alu_result;
  logic         alu_cin, alu_sub, alu_cout, alu_hout, busy;

  alu16_sequencer #(.N_BYTES(NB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sub(alu_sub),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_hout(alu_hout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [8:0] full;
  logic [4:0] half;
  always_comb begin
    if (alu_sub) begin
      full = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
      half = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'b0, alu_cin};
    end else begin
      full = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
      half = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, alu_cin};
    end
    alu_result = full[7:0];
    alu_cout   = full[8];
    alu_hout   = half[4];
  end

  typedef struct {
    logic [W-1:0] res;
    logic [7:0]   flg;
    int           acc;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: latency on the rising edge of rsp_valid, data on the handshake.
  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) begin
      if (sbq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else chk("latency", 32'(cyc - sbq[0].acc), 32'(NB));
    end
    if (rsp_valid && rsp_ready && sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rsp_result", 32'(rsp_result), 32'(e.res));
      chk("rsp_flags", 32'(rsp_flags), 32'(e.flg));
    end
    prev_valid = rsp_valid;
  end

  // Inputs change at posedge+1 so the negedge monitor sees what the next edge will use.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [7:0] f, input logic [W-1:0] er, input logic [7:0] ef);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_flags = f;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    sbq.push_back('{er, ef, cyc});
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_alu_out"}, 32'({alu_a, alu_b, alu_cin, alu_sub}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_a = '0; req_b = '0; req_flags = '0;
    #1;
    chk_reset_vals("por");
    #20 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);

    issue(2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4);
    issue(2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94);
    issue(2'b10, 16'h0000, 16'h0001, 8'h00, 16'hFFFF, 8'h93);
    issue(2'b10, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42);
    issue(2'b11, 16'hABCD, 16'h5555, 8'h5A, 16'hABCD, 8'h5A);
    issue(2'b01, 16'h00FF, 16'h0000, 8'h01, 16'h0100, 8'h00);
    issue(2'b00, 16'h8000, 16'h8000, 8'h28, 16'h0000, 8'h29);
    drain();

    // Consumer stall with a different request waiting on the input.
    rsp_ready = 1'b0;
    issue(2'b00, 16'h1111, 16'h2222, 8'h00, 16'h3333, 8'h00);
    req_valid = 1'b1; req_op = 2'b10; req_a = 16'h0005; req_b = 16'h0003; req_flags = 8'h01;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_rsp_seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", 32'(rsp_result), 32'h3333);
      chk("stall_flags", 32'(rsp_flags), 32'h00);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(2'b10, 16'h0005, 16'h0003, 8'h01, 16'h0001, 8'h02);
    drain();

    // Asynchronous reset in the second pass cycle.
    issue(2'b00, 16'h0102, 16'h0304, 8'h00, 16'h0406, 8'h00);
    @(posedge clk); #1;
    chk("pass1_alu_a", 32'(alu_a), 32'h01);
    chk("pass1_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    void'(sbq.pop_back());
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midreset", 32'(req_ready), 32'd1);
    issue(2'b00, 16'h0001, 16'h0001, 8'h00, 16'h0002, 8'h00);
    drain();

    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
